// File: rtl/cmp_deglitch_counter.sv
// Comparator deglitcher: 2-flop synchronizer, stability-filter FSM, saturating
// rising-edge counter with sticky overflow, and a req/ack snapshot register.
module cmp_deglitch_counter #(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmp_in,
    input  logic             clear,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             cmp_filt,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic [CNT_W:0]   snap_data,
    output logic             snap_valid
);

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_PEND_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_PEND_L = 2'd3
    } filt_state_t;

    localparam logic [3:0]       STAB_LAST = 4'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]  sync_q;
    logic        cmp_s;
    filt_state_t state, state_next;
    logic [3:0]  stab, stab_next;
    logic        enter_high;
    logic        enter_low;

    // The synchronizer keeps sampling while disabled so cmp_s is never stale.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], cmp_in};
        end
    end

    assign cmp_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOW;
            stab  <= 4'd0;
        end else if (ena) begin
            state <= state_next;
            stab  <= stab_next;
        end
    end

    // NOTE: defaults ahead of the case keep this purely combinational; any
    // path that skipped an assignment would otherwise infer a latch.
    always_comb begin
        state_next = state;
        stab_next  = stab;
        case (state)
            ST_LOW: begin
                if (cmp_s) begin
                    state_next = ST_PEND_H;
                    stab_next  = 4'd1;
                end
            end
            ST_PEND_H: begin
                if (!cmp_s) begin
                    state_next = ST_LOW;
                    stab_next  = 4'd0;
                end else if (stab == STAB_LAST) begin
                    state_next = ST_HIGH;
                    stab_next  = 4'd0;
                end else begin
                    stab_next  = stab + 4'd1;
                end
            end
            ST_HIGH: begin
                if (!cmp_s) begin
                    state_next = ST_PEND_L;
                    stab_next  = 4'd1;
                end
            end
            ST_PEND_L: begin
                if (cmp_s) begin
                    state_next = ST_HIGH;
                    stab_next  = 4'd0;
                end else if (stab == STAB_LAST) begin
                    state_next = ST_LOW;
                    stab_next  = 4'd0;
                end else begin
                    stab_next  = stab + 4'd1;
                end
            end
        endcase
    end

    // Only PEND_H->HIGH and PEND_L->LOW change the filtered level.
    always_comb begin
        cmp_filt   = (state == ST_HIGH) || (state == ST_PEND_L);
        enter_high = ena && (state == ST_PEND_H) && (state_next == ST_HIGH);
        enter_low  = ena && (state == ST_PEND_L) && (state_next == ST_LOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= enter_high;
            fall_pulse <= enter_low;
        end
    end

    // Clear wins over a same-edge increment; overflow is sticky until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (enter_high) begin
            if (count == CNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Snapshot captures pre-edge values, so req together with clear reads the
    // old count while the counter is zeroed. An ack drops a same-cycle req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_data  <= '0;
            snap_valid <= 1'b0;
        end else if (snap_valid) begin
            if (snap_ack) begin
                snap_valid <= 1'b0;
            end
        end else if (snap_req) begin
            snap_data  <= {overflow, count};
            snap_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cmp_deglitch_counter.sv
// Scoreboard bench for cmp_deglitch_counter: a run-length reference model
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_cmp_deglitch_counter;

    localparam int FILT_LEN = 4;
    localparam int CNT_W    = 8;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             cmp_in;
    logic             clear;
    logic             snap_req;
    logic             snap_ack;
    logic             cmp_filt;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [CNT_W:0]   snap_data;
    logic             snap_valid;

    cmp_deglitch_counter #(.FILT_LEN(FILT_LEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmp_in    (cmp_in),
        .clear     (clear),
        .snap_req  (snap_req),
        .snap_ack  (snap_ack),
        .cmp_filt  (cmp_filt),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .count     (count),
        .overflow  (overflow),
        .snap_data (snap_data),
        .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           filt;
        logic           rise;
        logic           fall;
        int             cnt;
        logic           ovf;
        logic [CNT_W:0] sd;
        logic           sv;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: synchronizer as a 2-deep delay line, filter as a
    // run-length count of enabled samples disagreeing with the accepted level.
    logic [1:0]     m_sync;
    logic           m_lvl;
    int             m_run;
    int             m_cnt;
    logic           m_ovf;
    logic [CNT_W:0] m_sd;
    logic           m_sv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_sync = 2'b00;
        m_lvl  = 1'b0;
        m_run  = 0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_sd   = '0;
        m_sv   = 1'b0;
    endtask

    // Called at negedge+1: drive one cycle, predict post-edge outputs, advance.
    task automatic step(input logic ci, input logic e, input logic clr,
                        input logic req, input logic ack);
        exp_t           x;
        logic           cs;
        logic           r;
        logic           f;
        int             c_pre;
        logic           o_pre;
        logic [CNT_W-1:0] cv;
        cmp_in   = ci;
        ena      = e;
        clear    = clr;
        snap_req = req;
        snap_ack = ack;
        cs     = m_sync[1];
        m_sync = {m_sync[0], ci};
        r = 1'b0;
        f = 1'b0;
        if (e) begin
            if (cs != m_lvl) begin
                m_run++;
                if (m_run == FILT_LEN) begin
                    m_lvl = ~m_lvl;
                    m_run = 0;
                    r = m_lvl;
                    f = ~m_lvl;
                end
            end else begin
                m_run = 0;
            end
        end
        c_pre = m_cnt;
        o_pre = m_ovf;
        if (clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (r) begin
            if (m_cnt == MAXC) m_ovf = 1'b1;
            else m_cnt++;
        end
        if (m_sv && ack) begin
            m_sv = 1'b0;
        end else if (!m_sv && req) begin
            cv   = c_pre[CNT_W-1:0];
            m_sd = {o_pre, cv};
            m_sv = 1'b1;
        end
        x.filt = m_lvl;
        x.rise = r;
        x.fall = f;
        x.cnt  = m_cnt;
        x.ovf  = m_ovf;
        x.sd   = m_sd;
        x.sv   = m_sv;
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_filt"}, 32'(cmp_filt), 32'd0);
        check({tag, "_rise"}, 32'(rise_pulse), 32'd0);
        check({tag, "_fall"}, 32'(fall_pulse), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_sdata"}, 32'(snap_data), 32'd0);
        check({tag, "_svalid"}, 32'(snap_valid), 32'd0);
    endtask

    // Called at negedge+1 with the scoreboard drained; holds reset one cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        @(negedge clk);
        #1;
        check_all_zero("rst_held");
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check("cmp_filt", 32'(cmp_filt), 32'(x.filt));
            check("rise_pulse", 32'(rise_pulse), 32'(x.rise));
            check("fall_pulse", 32'(fall_pulse), 32'(x.fall));
            check("count", 32'(count), 32'(x.cnt));
            check("overflow", 32'(overflow), 32'(x.ovf));
            check("snap_valid", 32'(snap_valid), 32'(x.sv));
            check("snap_data", 32'(snap_data), 32'(x.sd));
        end
    end

    initial begin
        logic cur;
        int   hold;
        rst_n    = 1'b1;
        ena      = 1'b1;
        cmp_in   = 1'b1;
        clear    = 1'b0;
        snap_req = 1'b0;
        snap_ack = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        do_reset();

        // Clean low, then a long high: acceptance after FILT_LEN+2 edges.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 4) check("lat_before_edge6", 32'(cmp_filt), 32'd0);
            if (i == 5) check("lat_after_edge6", 32'(cmp_filt), 32'd1);
        end
        check("count_after_rise", 32'(count), 32'd1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Short glitch rejected.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("glitch_count", 32'(count), 32'd0);

        // Saturation and sticky overflow, then clear.
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (p == 254) check("sat_no_ovf_yet", 32'(overflow), 32'd0);
        end
        check("sat_count", 32'(count), 32'(MAXC));
        check("sat_ovf", 32'(overflow), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);

        // Count to 5, read-and-clear snapshot, ignored second req, ack.
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("snap_rc_data", 32'(snap_data), 32'h005);
        check("snap_rc_valid", 32'(snap_valid), 32'd1);
        check("snap_rc_count", 32'(count), 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("snap_ignored", 32'(snap_data), 32'h005);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("snap_acked", 32'(snap_valid), 32'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset while pending high discards partial stability.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 4) check("rst_pend_before", 32'(cmp_filt), 32'd0);
            if (i == 5) check("rst_pend_after", 32'(cmp_filt), 32'd1);
        end

        // Randomized traffic with enable gaps, clears and snapshot handshakes.
        cur  = 1'b0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            logic e;
            logic clr;
            if (hold == 0) begin
                cur  = ~cur;
                hold = int'($urandom_range(1, 7));
            end
            hold--;
            e   = ($urandom_range(0, 9) != 0);
            clr = e && ($urandom_range(0, 49) == 0);
            step(cur, e, clr, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
        end

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
